// File: rtl/ldpc_3gpp_dec_cnode_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_3gpp_dec_cnode_ctrl_pkg
// Shared types for the 3GPP LDPC decoder check-node sequencing logic.
//   strb_t       : frame/packet strobes that go with every issued cycle
//   ctrl_state_t : sequencer FSM states
//   c*_W / cDRAIN_MAX : default widths and watchdog limit (BG1 sizing)
// ---------------------------------------------------------------------------
package ldpc_3gpp_dec_cnode_ctrl_pkg;

  localparam int cROW_W     = 6;   // up to 46 base-matrix rows (BG1)
  localparam int cCYC_W     = 5;
  localparam int cITER_W    = 6;
  localparam int cDRAIN_MAX = 63;

  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
  } strb_t;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_RUN,
    CTRL_DRAIN,
    CTRL_DONE
  } ctrl_state_t;

endpackage

// File: rtl/ldpc_3gpp_dec_row_cycle_cnt.sv
// ---------------------------------------------------------------------------
// ldpc_3gpp_dec_row_cycle_cnt
// Nested row / column-group-cycle counter for the check-node sequencer.
// The inner cycle counter wraps at icycle_num and carries into the row
// counter. Strobes and the last-issue flag are decoded from the registered
// counters, so they carry no combinational path from the inputs of the
// parent block other than the latched configuration.
//
// Ports:
//   iclk, ireset, iclkena : clock, sync active-high reset, clock enable
//   iclear                : return to row 0 / cycle 0 (has priority)
//   iadvance              : step to the next cycle of the frame
//   irow_num, icycle_num  : latched rows-1 / cycles-per-row-1
//   orow, ocycle          : current position in the frame
//   ostrb                 : sof/sop/eop/eof for the current position
//   olast                 : current position is the last of the frame
// ---------------------------------------------------------------------------
module ldpc_3gpp_dec_row_cycle_cnt
  import ldpc_3gpp_dec_cnode_ctrl_pkg::*;
#(
  parameter int pROW_W = cROW_W,
  parameter int pCYC_W = cCYC_W
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              iclear,
  input  logic              iadvance,
  input  logic [pROW_W-1:0] irow_num,
  input  logic [pCYC_W-1:0] icycle_num,
  output logic [pROW_W-1:0] orow,
  output logic [pCYC_W-1:0] ocycle,
  output strb_t             ostrb,
  output logic              olast
);

  logic [pROW_W-1:0] r_row;
  logic [pCYC_W-1:0] r_cycle;
  logic              w_sop;
  logic              w_eop;
  logic              w_row_first;
  logic              w_row_last;

  assign w_sop       = (r_cycle == '0);
  assign w_eop       = (r_cycle == icycle_num);
  assign w_row_first = (r_row == '0);
  assign w_row_last  = (r_row == irow_num);

  assign ostrb.sof = w_row_first & w_sop;
  assign ostrb.sop = w_sop;
  assign ostrb.eop = w_eop;
  assign ostrb.eof = w_row_last & w_eop;
  assign olast     = w_row_last & w_eop;

  assign orow   = r_row;
  assign ocycle = r_cycle;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_row   <= '0;
      r_cycle <= '0;
    end else if (iclkena) begin
      if (iclear) begin
        r_row   <= '0;
        r_cycle <= '0;
      end else if (iadvance) begin
        // The parent never advances past the last issue, so the row
        // counter needs no wrap of its own.
        if (w_eop) begin
          r_cycle <= '0;
          r_row   <= r_row + pROW_W'(1);
        end else begin
          r_cycle <= r_cycle + pCYC_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ldpc_3gpp_dec_cnode_ctrl.sv
// ---------------------------------------------------------------------------
// ldpc_3gpp_dec_cnode_ctrl
// Sequencer for the check-node arithmetic engine. For every decoding
// iteration it issues one cycle per (row, column-group cycle) of the base
// matrix, then waits for the engine end-of-frame, and either starts another
// iteration or finishes (early termination on parity pass, or iteration
// limit). A watchdog bounds the wait for the engine.
//
// Ports:
//   iclk, ireset, iclkena : clock, sync active-high reset, clock enable
//   istart                : start decode (honoured only when idle)
//   irow_num, icycle_num  : rows-1, cycles-per-row-1 (latched at start)
//   initer                : max iterations, 0 behaves as 1 (latched)
//   iearly_stop           : allow early termination (latched)
//   ieng_oval/ostrb/odecfail : engine output handshake and parity flag
//   oval, ostrb, orow, ocycle : issued cycle to the engine / read logic
//   obusy, odone          : busy level and one-cycle completion pulse
//   oiter, odecfail, oerr : iterations done, last decfail, watchdog hit
// ---------------------------------------------------------------------------
module ldpc_3gpp_dec_cnode_ctrl
  import ldpc_3gpp_dec_cnode_ctrl_pkg::*;
#(
  parameter int pROW_W     = cROW_W,
  parameter int pCYC_W     = cCYC_W,
  parameter int pITER_W    = cITER_W,
  parameter int pDRAIN_MAX = cDRAIN_MAX
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pROW_W-1:0]  irow_num,
  input  logic [pCYC_W-1:0]  icycle_num,
  input  logic [pITER_W-1:0] initer,
  input  logic               iearly_stop,
  input  logic               ieng_oval,
  input  strb_t              ieng_ostrb,
  input  logic               ieng_odecfail,
  output logic               oval,
  output strb_t              ostrb,
  output logic [pROW_W-1:0]  orow,
  output logic [pCYC_W-1:0]  ocycle,
  output logic               obusy,
  output logic               odone,
  output logic [pITER_W-1:0] oiter,
  output logic               odecfail,
  output logic               oerr
);

  localparam int cWD_W = $clog2(pDRAIN_MAX + 1);

  ctrl_state_t        r_state;
  ctrl_state_t        w_state_nxt;

  logic [pROW_W-1:0]  r_row_num;
  logic [pCYC_W-1:0]  r_cyc_num;
  logic [pITER_W-1:0] r_iter_max;
  logic               r_early;
  logic [pITER_W-1:0] r_oiter;
  logic               r_odecfail;
  logic               r_oerr;
  logic [cWD_W-1:0]   r_wdog;

  logic               w_evt;
  logic               w_stop;
  logic               w_wd_exp;
  logic               w_clear;
  logic               w_advance;
  logic               w_last;
  logic [pITER_W:0]   w_iter_inc;
  strb_t              w_strb;
  logic [pROW_W-1:0]  w_row;
  logic [pCYC_W-1:0]  w_cycle;
  logic [1:0]         w_unused_strb;

  function automatic logic [pITER_W-1:0] iter_limit(input logic [pITER_W-1:0] n);
    return (n == '0) ? pITER_W'(1) : n;
  endfunction

  ldpc_3gpp_dec_row_cycle_cnt #(
    .pROW_W (pROW_W),
    .pCYC_W (pCYC_W)
  ) u_cnt (
    .iclk       (iclk),
    .ireset     (ireset),
    .iclkena    (iclkena),
    .iclear     (w_clear),
    .iadvance   (w_advance),
    .irow_num   (r_row_num),
    .icycle_num (r_cyc_num),
    .orow       (w_row),
    .ocycle     (w_cycle),
    .ostrb      (w_strb),
    .olast      (w_last)
  );

  // Only the frame-closing strobes of the engine matter here.
  assign w_unused_strb = {ieng_ostrb.sof, ieng_ostrb.sop};

  assign w_evt      = ieng_oval & ieng_ostrb.eop & ieng_ostrb.eof;
  assign w_iter_inc = {1'b0, r_oiter} + (pITER_W+1)'(1);
  assign w_stop     = (r_early & ~ieng_odecfail) | (w_iter_inc >= {1'b0, r_iter_max});
  // r_wdog counts DRAIN cycles already spent; the cycle holding the
  // limit-1 value is the last one allowed.
  assign w_wd_exp   = (r_wdog == cWD_W'(pDRAIN_MAX - 1));

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= CTRL_IDLE;
    end else if (iclkena) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      CTRL_IDLE: begin
        if (istart) begin
          w_state_nxt = CTRL_RUN;
          w_clear     = 1'b1;
        end
      end
      CTRL_RUN: begin
        if (w_last) begin
          w_state_nxt = CTRL_DRAIN;
        end else begin
          w_advance = 1'b1;
        end
      end
      CTRL_DRAIN: begin
        // The engine event takes priority over a simultaneous expiry.
        if (w_evt) begin
          if (w_stop) begin
            w_state_nxt = CTRL_DONE;
          end else begin
            w_state_nxt = CTRL_RUN;
            w_clear     = 1'b1;
          end
        end else if (w_wd_exp) begin
          w_state_nxt = CTRL_DONE;
        end
      end
      CTRL_DONE: begin
        w_state_nxt = CTRL_IDLE;
      end
      default: begin
        w_state_nxt = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_row_num  <= '0;
      r_cyc_num  <= '0;
      r_iter_max <= '0;
      r_early    <= 1'b0;
      r_oiter    <= '0;
      r_odecfail <= 1'b0;
      r_oerr     <= 1'b0;
      r_wdog     <= '0;
    end else if (iclkena) begin
      case (r_state)
        CTRL_IDLE: begin
          if (istart) begin
            r_row_num  <= irow_num;
            r_cyc_num  <= icycle_num;
            r_iter_max <= iter_limit(initer);
            r_early    <= iearly_stop;
            r_oiter    <= '0;
            r_odecfail <= 1'b0;
            r_oerr     <= 1'b0;
          end
        end
        CTRL_RUN: begin
          if (w_last) begin
            r_wdog <= '0;
          end
        end
        CTRL_DRAIN: begin
          if (w_evt) begin
            r_oiter    <= w_iter_inc[pITER_W-1:0];
            r_odecfail <= ieng_odecfail;
            r_wdog     <= '0;
          end else if (w_wd_exp) begin
            r_oerr <= 1'b1;
          end else begin
            r_wdog <= r_wdog + cWD_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign oval     = (r_state == CTRL_RUN);
  assign ostrb    = oval ? w_strb : '0;
  assign orow     = w_row;
  assign ocycle   = w_cycle;
  assign obusy    = (r_state != CTRL_IDLE);
  assign odone    = (r_state == CTRL_DONE);
  assign oiter    = r_oiter;
  assign odecfail = r_odecfail;
  assign oerr     = r_oerr;

endmodule

// File: tb/tb_ldpc_3gpp_dec_cnode_ctrl.sv
`timescale 1ns/1ps
module tb_ldpc_3gpp_dec_cnode_ctrl;
  import ldpc_3gpp_dec_cnode_ctrl_pkg::*;

  logic       iclk = 1'b0;
  logic       ireset = 1'b1;
  logic       iclkena = 1'b1;
  logic       istart = 1'b0;
  logic [5:0] irow_num = '0;
  logic [4:0] icycle_num = '0;
  logic [5:0] initer = '0;
  logic       iearly_stop = 1'b0;
  logic       ieng_oval = 1'b0;
  strb_t      ieng_ostrb = '0;
  logic       ieng_odecfail = 1'b0;
  logic       oval;
  strb_t      ostrb;
  logic [5:0] orow;
  logic [4:0] ocycle;
  logic       obusy;
  logic       odone;
  logic [5:0] oiter;
  logic       odecfail;
  logic       oerr;

  ldpc_3gpp_dec_cnode_ctrl dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
    .irow_num(irow_num), .icycle_num(icycle_num), .initer(initer),
    .iearly_stop(iearly_stop), .ieng_oval(ieng_oval), .ieng_ostrb(ieng_ostrb),
    .ieng_odecfail(ieng_odecfail), .oval(oval), .ostrb(ostrb), .orow(orow),
    .ocycle(ocycle), .obusy(obusy), .odone(odone), .oiter(oiter),
    .odecfail(odecfail), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [5:0] row;
    logic [4:0] cyc;
    strb_t      strb;
  } issue_t;

  typedef struct {
    logic [5:0] iter;
    logic       decfail;
    logic       err;
    int         lat;
  } done_t;

  issue_t exp_issue[$];
  done_t  exp_done[$];
  done_t  last_done;

  int total = 0;
  int bad = 0;
  int n_issue = 0;
  int n_done = 0;
  bit ce_rand = 1'b0;
  int eng_lat = 6;
  bit eng_never = 1'b0;
  bit eng_dec[64];
  int eng_idx = 0;
  int eng_cnt = 0;
  int drain_cnt = 0;
  bit in_drain = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Clock enable: either always on, or a fair coin per cycle.
  initial forever begin
    @(posedge iclk);
    #1;
    iclkena = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Engine model: after the frame's eof issue, answers eop+eof after
  // eng_lat enabled cycles; otherwise emits random non-closing outputs.
  initial forever begin
    @(negedge iclk);
    if (ireset) begin
      ieng_oval = 1'b0;
      ieng_ostrb = '0;
      eng_cnt = 0;
    end else if (iclkena) begin
      ieng_oval = 1'b0;
      ieng_ostrb = '0;
      ieng_odecfail = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          ieng_oval = 1'b1;
          ieng_ostrb.eop = 1'b1;
          ieng_ostrb.eof = 1'b1;
          ieng_odecfail = eng_dec[eng_idx];
          if (eng_idx < 63) eng_idx++;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        ieng_odecfail = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: begin ieng_oval = 1'b1; ieng_ostrb.eop = 1'b1; end
          1: begin ieng_oval = 1'b1; ieng_ostrb.eof = 1'b1; end
          2: begin ieng_oval = 1'b0; ieng_ostrb.eop = 1'b1; ieng_ostrb.eof = 1'b1; end
          default: begin ieng_oval = 1'b1; ieng_ostrb.sof = 1'b1; ieng_ostrb.sop = 1'b1; end
        endcase
      end
      if (oval && ostrb.eof && !eng_never) eng_cnt = eng_lat;
    end
  end

  // Monitor / scoreboard: one entry per consumed issue and per done pulse.
  initial begin
    issue_t e;
    done_t  d;
    forever begin
      @(negedge iclk);
      if (ireset) begin
        in_drain = 1'b0;
      end else if (iclkena) begin
        if (oval) begin
          n_issue++;
          chk("issue_expected", 32'(exp_issue.size() != 0), 32'd1);
          if (exp_issue.size() != 0) begin
            e = exp_issue.pop_front();
            chk("issue_row_cyc_strb", 32'({orow, ocycle, ostrb}), 32'({e.row, e.cyc, e.strb}));
          end
          chk("issue_busy", 32'(obusy), 32'd1);
          if (ostrb.eof) begin
            in_drain = 1'b1;
            drain_cnt = 0;
          end
        end else if (in_drain && !odone) begin
          drain_cnt++;
        end
        if (odone) begin
          n_done++;
          chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
          if (exp_done.size() != 0) begin
            d = exp_done.pop_front();
            chk("done_iter", 32'(oiter), 32'(d.iter));
            chk("done_decfail", 32'(odecfail), 32'(d.decfail));
            chk("done_err", 32'(oerr), 32'(d.err));
            chk("done_drain_len", 32'(drain_cnt), 32'(d.lat));
          end
          chk("done_busy", 32'(obusy), 32'd1);
          in_drain = 1'b0;
        end
      end
    end
  end

  // Reference model: whole frames of (row, cycle) in raster order per
  // iteration; iteration count from the early-stop / limit rules.
  task automatic build_exp(input int rn, input int cn, input int ni, input bit es,
                           input bit never, input int lat, input int max_iss, input bit want_done);
    int eff;
    int it;
    int pushed;
    bit df;
    bit stop;
    issue_t e;
    done_t d;
    eff = (ni == 0) ? 1 : ni;
    it = 0; pushed = 0; df = 1'b0; stop = 1'b0;
    while (!stop) begin
      for (int r = 0; r <= rn; r++) begin
        for (int c = 0; c <= cn; c++) begin
          e.row = 6'(r);
          e.cyc = 5'(c);
          e.strb.sop = (c == 0);
          e.strb.eop = (c == cn);
          e.strb.sof = (r == 0) && (c == 0);
          e.strb.eof = (r == rn) && (c == cn);
          if (pushed < max_iss) begin
            exp_issue.push_back(e);
            pushed++;
          end
        end
      end
      if (never) begin
        stop = 1'b1;
      end else begin
        df = eng_dec[it];
        it++;
        stop = (es && !df) || (it >= eff);
      end
    end
    d.iter = 6'(it);
    d.decfail = df;
    d.err = never;
    d.lat = never ? 63 : lat;
    if (want_done) begin
      exp_done.push_back(d);
      last_done = d;
    end
  endtask

  task automatic start_case(input int rn, input int cn, input int ni, input bit es);
    int t;
    t = 0;
    do begin
      @(negedge iclk);
      t++;
    end while (!(iclkena && !obusy) && t < 1000);
    chk("idle_before_start", 32'(obusy), 32'd0);
    irow_num = 6'(rn);
    icycle_num = 5'(cn);
    initer = 6'(ni);
    iearly_stop = es;
    istart = 1'b1;
    @(posedge iclk);
    #2;
    // Later config changes and a held start must not disturb the decode.
    irow_num = 6'($urandom_range(0, 63));
    icycle_num = 5'($urandom_range(0, 31));
    initer = 6'($urandom_range(0, 63));
    iearly_stop = 1'($urandom_range(0, 1));
    @(posedge iclk);
    #2;
    istart = 1'b0;
  endtask

  task automatic recover();
    @(posedge iclk);
    #1 ireset = 1'b1;
    repeat (2) @(posedge iclk);
    #1 ireset = 1'b0;
    exp_issue.delete();
    exp_done.delete();
  endtask

  task automatic run_case(input string tag, input int rn, input int cn, input int ni,
                          input bit es, input bit never, input int lat, input bit ce);
    int base;
    int t;
    eng_never = never;
    eng_lat = lat;
    eng_idx = 0;
    ce_rand = ce;
    build_exp(rn, cn, ni, es, never, lat, 1 << 30, 1'b1);
    base = n_done;
    start_case(rn, cn, ni, es);
    t = 0;
    while (n_done == base && t < 20000) begin
      @(negedge iclk);
      t++;
    end
    chk({tag, "_finished"}, 32'(t < 20000), 32'd1);
    if (t >= 20000) begin
      recover();
    end else begin
      chk({tag, "_issues_left"}, 32'(exp_issue.size()), 32'd0);
      t = 0;
      do begin
        @(negedge iclk);
        t++;
      end while (obusy && t < 100);
      chk({tag, "_idle_hold"}, 32'({obusy, oiter, odecfail, oerr}),
          32'({1'b0, last_done.iter, last_done.decfail, last_done.err}));
    end
  endtask

  initial begin
    int bi;
    int bd;
    int t;
    ce_rand = 1'b1;
    ireset = 1'b1;
    repeat (4) @(posedge iclk);
    #1 ireset = 1'b0;
    ce_rand = 1'b0;
    @(negedge iclk);
    chk("rst_oval", 32'(oval), 32'd0);
    chk("rst_ostrb", 32'(ostrb), 32'd0);
    chk("rst_orow", 32'(orow), 32'd0);
    chk("rst_ocycle", 32'(ocycle), 32'd0);
    chk("rst_obusy", 32'(obusy), 32'd0);
    chk("rst_odone", 32'(odone), 32'd0);
    chk("rst_oiter", 32'(oiter), 32'd0);
    chk("rst_odecfail", 32'(odecfail), 32'd0);
    chk("rst_oerr", 32'(oerr), 32'd0);

    eng_dec[0] = 1'b1;
    run_case("basic", 2, 3, 1, 1'b0, 1'b0, 6, 1'b0);

    eng_dec[0] = 1'b1; eng_dec[1] = 1'b1; eng_dec[2] = 1'b0; eng_dec[3] = 1'b1;
    run_case("early", 2, 3, 4, 1'b1, 1'b0, 6, 1'b0);
    run_case("noearly", 2, 3, 4, 1'b0, 1'b0, 6, 1'b0);

    for (int i = 0; i < 64; i++) eng_dec[i] = 1'($urandom_range(0, 1));
    run_case("single", 0, 0, 3, 1'b0, 1'b0, 4, 1'b0);
    run_case("wdog", 1, 2, 2, 1'b0, 1'b1, 6, 1'b0);
    run_case("tie", 0, 1, 1, 1'b0, 1'b0, 63, 1'b0);
    run_case("iter0", 1, 1, 0, 1'b0, 1'b0, 5, 1'b0);
    run_case("clkena", 2, 3, 2, 1'b0, 1'b0, 6, 1'b1);

    // Reset after the fifth issue of RUN: no done pulse, back to idle.
    ce_rand = 1'b0;
    eng_never = 1'b0;
    eng_lat = 6;
    eng_idx = 0;
    build_exp(2, 3, 2, 1'b0, 1'b0, 6, 5, 1'b0);
    bi = n_issue;
    bd = n_done;
    start_case(2, 3, 2, 1'b0);
    t = 0;
    while (n_issue < bi + 5 && t < 200) begin
      @(posedge iclk);
      t++;
    end
    chk("rst_mid_reach", 32'(n_issue - bi), 32'd5);
    #1 ireset = 1'b1;
    repeat (2) @(posedge iclk);
    #1 ireset = 1'b0;
    @(negedge iclk);
    chk("rst_mid_oval", 32'(oval), 32'd0);
    chk("rst_mid_obusy", 32'(obusy), 32'd0);
    chk("rst_mid_oiter", 32'(oiter), 32'd0);
    repeat (10) @(negedge iclk);
    chk("rst_mid_no_done", 32'(n_done - bd), 32'd0);
    chk("rst_mid_issues_left", 32'(exp_issue.size()), 32'd0);

    eng_dec[0] = 1'b0;
    run_case("fresh", 2, 3, 1, 1'b0, 1'b0, 6, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 64; i++) eng_dec[i] = 1'($urandom_range(0, 1));
      run_case("rand", $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 20), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_3gpp_dec_cnode_ctrl.md
Name: ldpc_3gpp_dec_cnode_ctrl

Overview:
- Sequencer for the check-node arithmetic engine in the 3GPP LDPC decoder.
- Walks the rows of the base matrix and the column-group cycles inside each row for every decoding iteration, and drives the engine's `ival`/`istrb`.
- Drains the engine at the end of each iteration, then uses the engine's frame-level `odecfail` for early termination or runs to the iteration limit.
- Sits between the decoder top-level FSM and the vnode read/address logic feeding the engine.

Parameters:
- pROW_W, 6, width of row counter (max 46 rows, BG1)
- pCYC_W, 5, width of per-row cycle counter
- pITER_W, 6, width of iteration counter
- pDRAIN_MAX, 63, watchdog limit in enabled cycles spent waiting for engine end-of-frame

Ports:
- iclk, in, 1, clock
- ireset, in, 1, synchronous active-high reset
- iclkena, in, 1, clock enable; all state holds when low
- istart, in, 1, start decode; sampled only in IDLE
- irow_num, in, pROW_W, rows used minus 1, latched at start
- icycle_num, in, pCYC_W, cycles per row minus 1, latched at start
- initer, in, pITER_W, max iterations; 0 is treated as 1; latched
- iearly_stop, in, 1, enable early termination; latched
- ieng_oval, in, 1, engine output valid
- ieng_ostrb, in, strb_t, engine output strobe
- ieng_odecfail, in, 1, engine parity-fail flag
- oval, out, 1, issue one cycle to engine and read logic
- ostrb, out, strb_t, sof/sop/eop/eof for the issued cycle
- orow, out, pROW_W, row index of issued cycle
- ocycle, out, pCYC_W, cycle index inside row
- obusy, out, 1, high from accepted start through DONE
- odone, out, 1, one-cycle completion pulse
- oiter, out, pITER_W, iterations completed
- odecfail, out, 1, final engine decfail at completion
- oerr, out, 1, watchdog expiry, valid with odone

Behaviour:
- Reset (synchronous, overrides iclkena): state IDLE. All outputs 0, counters 0.
- All transitions and registers advance only when iclkena=1. With iclkena=0, outputs hold.

States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On istart: latch config, clear oiter/odecfail/oerr, row=cycle=0, obusy=1, go RUN.
- RUN:
  - oval=1 every enabled cycle; orow/ocycle are registered outputs with no combinational path from inputs.
  - ocycle increments; at icycle_num it wraps to 0 and orow increments.
  - Strobes:
    - sop=1 when ocycle==0.
    - eop=1 when ocycle==icycle_num.
    - sof=1 when orow==0 and ocycle==0.
    - eof=1 when orow==irow_num and eop.
  - On the issue with eof: next state DRAIN, oval=0 thereafter. Watchdog counter is cleared on entry.
- DRAIN:
  - Wait for ieng_oval & ieng_ostrb.eop & ieng_ostrb.eof.
  - On that event:
    - oiter+=1, odecfail<=ieng_odecfail.
    - If (iearly_stop & !ieng_odecfail) or oiter+1 >= max(initer,1): go DONE.
    - Else: row=cycle=0, go RUN.
  - Watchdog: count enabled cycles. If pDRAIN_MAX is reached without the event, oerr=1 and go DONE.
  - Engine outputs that are not end-of-frame are ignored.
- DONE:
  - odone=1 for one cycle, obusy=1.
  - Next state IDLE; obusy falls.
  - oiter/odecfail/oerr hold until the next accepted start.

Boundaries and corner cases:
- icycle_num=0: sop and eop in the same cycle.
- irow_num=0 with icycle_num=0: a one-cycle frame with sof/sop/eop/eof all set.
- istart outside IDLE is ignored.
- An eof event and watchdog expiry on the same cycle: the event wins, oerr=0.
- Reset mid-RUN/DRAIN: IDLE on the next edge, oval drops, odone is not pulsed.
- Counter arithmetic is unsigned. Config changes after start have no effect.

Decomposition:
- The shared decoder types package already holds `strb_t` (sof, sop, eop, eof); reuse it.
- Add `ctrl_state_t` enum and the width parameters there.
- One natural sub-module: `ldpc_3gpp_dec_row_cycle_cnt`, which implements the nested row/cycle counter with wrap, strobe generation and last-issue flag.

Test Plan:
- irow_num=2, icycle_num=3, initer=1, engine model with latency 6 returning decfail=1:
  - expect 12 oval cycles, with sof only on the 1st, eop on the 4th/8th/12th, eof on the 12th.
  - odone follows the engine eof; oiter=1, odecfail=1, oerr=0.
- initer=4, iearly_stop=1, engine returns decfail=1,1,0 per iteration:
  - expect 3 RUN bursts, oiter=3, odecfail=0.
- Same stimulus with iearly_stop=0:
  - expect 4 bursts, oiter=4.
- irow_num=0, icycle_num=0:
  - each iteration is a single oval with sof=sop=eop=eof=1.
- Engine never returns eof:
  - odone with oerr=1 after 63 enabled DRAIN cycles.
- Toggle iclkena 50% during RUN:
  - oval count and strobe positions are unchanged per enabled cycle.
- Assert ireset at cycle 5 of RUN:
  - state returns to IDLE, with no odone pulse.
- A fresh istart after the reset decodes normally.
